// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory bus: grants one requester, drives the bus, returns completion.
// Three cycles minimum per transfer (IDLE/XFER/DONE); waiting requesters hold their q level until dn/err.
module mem_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          req_read_q,
  input  logic [NREQ-1:0]          req_write_q,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [NREQ-1:0]          req_read_dn,
  output logic [NREQ-1:0]          req_write_dn,
  output logic [NREQ-1:0]          req_err,
  output logic [NREQ-1:0]          grant,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata,
  output logic                     bus_read_q,
  output logic                     bus_write_q,
  input  logic                     bus_read_dn,
  input  logic                     bus_write_dn,
  output logic                     bus_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_W  = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_ID = PW'(NREQ - 1);
  localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, winner, cur, idx;
  logic [PW:0]     sum;
  logic            any_pending, is_read, match_dn, timeout;
  logic [7:0]      cnt;
  logic [NREQ-1:0] pending;

  assign pending  = req_read_q | req_write_q;
  assign match_dn = is_read ? bus_read_dn : bus_write_dn;
  assign timeout  = (cnt == TO_LAST);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins last.
  always_comb begin
    winner      = '0;
    any_pending = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[PW-1:0];
      if (pending[idx]) begin
        winner      = idx;
        any_pending = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pending) state_nxt = XFER;
      XFER:    if (match_dn || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      req_rdata    <= '0;
      req_read_dn  <= '0;
      req_write_dn <= '0;
      req_err      <= '0;
      grant        <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_read_q   <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_busy     <= 1'b0;
      rr_ptr       <= '0;
      cur          <= '0;
      is_read      <= 1'b0;
      cnt          <= '0;
    end else begin
      req_read_dn  <= '0;
      req_write_dn <= '0;
      req_err      <= '0;
      case (state)
        IDLE: if (any_pending) begin
          grant       <= NREQ'(1) << winner;
          cur         <= winner;
          bus_addr    <= req_addr[winner*ADDR_W +: ADDR_W];
          bus_wdata   <= req_wdata[winner*DATA_W +: DATA_W];
          is_read     <= req_read_q[winner];
          bus_read_q  <= req_read_q[winner];
          bus_write_q <= !req_read_q[winner];
          bus_busy    <= 1'b1;
          cnt         <= '0;
        end
        XFER: begin
          cnt <= cnt + 8'd1;
          // A completion in the timeout cycle takes priority over the abort.
          if (match_dn) begin
            if (is_read) req_rdata <= bus_rdata;
            req_read_dn[cur]  <= is_read;
            req_write_dn[cur] <= !is_read;
            bus_read_q        <= 1'b0;
            bus_write_q       <= 1'b0;
          end else if (timeout) begin
            req_err[cur] <= 1'b1;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
          end
        end
        DONE: begin
          grant    <= '0;
          bus_busy <= 1'b0;
          cnt      <= '0;
          rr_ptr   <= (cur == LAST_ID) ? '0 : cur + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with 4 requesters; the memory side is driven by hand per test.
module tb_mem_bus_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [3:0]   req_read_q, req_write_q;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  req_rdata;
  logic [3:0]   req_read_dn, req_write_dn, req_err, grant;
  logic [31:0]  bus_addr, bus_wdata, bus_rdata;
  logic         bus_read_q, bus_write_q, bus_read_dn, bus_write_dn, bus_busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter #(.NREQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_read_q(req_read_q), .req_write_q(req_write_q),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_read_dn(req_read_dn), .req_write_dn(req_write_dn),
    .req_err(req_err), .grant(grant),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_read_q(bus_read_q), .bus_write_q(bus_write_q),
    .bus_read_dn(bus_read_dn), .bus_write_dn(bus_write_dn), .bus_busy(bus_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET        = 1'b0;
    req_read_q   = '0;
    req_write_q  = '0;
    req_addr     = '0;
    req_wdata    = '0;
    bus_rdata    = '0;
    bus_read_dn  = 1'b0;
    bus_write_dn = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(bus_busy), 32'h0);
    check("rst_strobes", {30'b0, bus_read_q, bus_write_q}, 32'h0);
    check("rst_rdata", req_rdata, 32'h0);

    // 1: single read, memory answers one cycle later
    req_read_q = 4'b0001;
    req_addr[31:0] = 32'd5;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_rq", 32'(bus_read_q), 32'h1);
    check("t1_addr", bus_addr, 32'd5);
    check("t1_busy", 32'(bus_busy), 32'h1);
    bus_read_dn = 1'b1;
    bus_rdata   = 32'hDEADBEEF;
    tick();
    bus_read_dn = 1'b0;
    req_read_q  = '0;
    check("t1_rdn", 32'(req_read_dn), 32'h1);
    check("t1_rdata", req_rdata, 32'hDEADBEEF);
    check("t1_rq_drop", 32'(bus_read_q), 32'h0);
    check("t1_done_busy", 32'(bus_busy), 32'h1);
    tick();
    check("t1_rdn_pulse", 32'(req_read_dn), 32'h0);
    check("t1_idle_grant", 32'(grant), 32'h0);
    check("t1_idle_busy", 32'(bus_busy), 32'h0);

    // 2: all four reading continuously, immediate answers
    do_reset();
    req_read_q = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("t2_grant%0d", g), 32'(grant), 32'(4'b0001 << (g % 4)));
      bus_read_dn = 1'b1;
      tick();
      bus_read_dn = 1'b0;
      check($sformatf("t2_rdn%0d", g), 32'(req_read_dn), 32'(4'b0001 << (g % 4)));
      tick();
      check($sformatf("t2_idle%0d", g), 32'(grant), 32'h0);
    end
    req_read_q = '0;

    // 3: read and write from one requester: read first, then write
    do_reset();
    req_read_q  = 4'b0100;
    req_write_q = 4'b0100;
    req_addr[95:64]  = 32'd7;
    req_wdata[95:64] = 32'h12345678;
    tick();
    check("t3_rgrant", 32'(grant), 32'h4);
    check("t3_rfirst", {30'b0, bus_read_q, bus_write_q}, 32'h2);
    bus_read_dn = 1'b1;
    bus_rdata   = 32'h0BADF00D;
    tick();
    bus_read_dn = 1'b0;
    req_read_q  = '0;
    check("t3_rdn", 32'(req_read_dn), 32'h4);
    tick();
    tick();
    check("t3_wgrant", 32'(grant), 32'h4);
    check("t3_wq", {30'b0, bus_read_q, bus_write_q}, 32'h1);
    check("t3_wdata", bus_wdata, 32'h12345678);
    check("t3_waddr", bus_addr, 32'd7);
    bus_write_dn = 1'b1;
    tick();
    bus_write_dn = 1'b0;
    req_write_q  = '0;
    check("t3_wdn", 32'(req_write_dn), 32'h4);
    check("t3_rdata_kept", req_rdata, 32'h0BADF00D);

    // 4: write never answered -> abort after 15 XFER cycles
    do_reset();
    req_write_q = 4'b0010;
    req_read_q  = 4'b1000;
    tick();
    check("t4_grant", 32'(grant), 32'h2);
    for (int c = 2; c <= 15; c++) tick();
    check("t4_last_xfer_wq", 32'(bus_write_q), 32'h1);
    check("t4_no_early_err", 32'(req_err), 32'h0);
    tick();
    req_write_q = '0;
    check("t4_err", 32'(req_err), 32'h2);
    check("t4_no_wdn", 32'(req_write_dn), 32'h0);
    check("t4_wq_drop", 32'(bus_write_q), 32'h0);
    tick();
    check("t4_err_pulse", 32'(req_err), 32'h0);
    tick();
    check("t4_next_grant", 32'(grant), 32'h8);
    bus_read_dn = 1'b1;
    tick();
    bus_read_dn = 1'b0;
    req_read_q  = '0;
    check("t4_next_rdn", 32'(req_read_dn), 32'h8);

    // 5: asynchronous reset in the middle of a transfer
    do_reset();
    req_read_q = 4'b1000;
    tick();
    check("t5_grant", 32'(grant), 32'h8);
    req_read_q = 4'b1001;
    #2 RESET = 1'b0;
    #1;
    check("t5_async_grant", 32'(grant), 32'h0);
    check("t5_async_rq", 32'(bus_read_q), 32'h0);
    bus_read_dn = 1'b1;
    tick();
    bus_read_dn = 1'b0;
    check("t5_no_rdn", 32'(req_read_dn), 32'h0);
    RESET = 1'b1;
    tick();
    check("t5_ptr0_grant", 32'(grant), 32'h1);
    bus_read_dn = 1'b1;
    tick();
    bus_read_dn = 1'b0;
    req_read_q  = '0;
    check("t5_rdn", 32'(req_read_dn), 32'h1);

    // 6: non-matching write done during a read is ignored
    do_reset();
    req_read_q = 4'b0001;
    tick();
    bus_write_dn = 1'b1;
    tick();
    bus_write_dn = 1'b0;
    check("t6_ign_rdn", 32'(req_read_dn), 32'h0);
    check("t6_ign_wdn", 32'(req_write_dn), 32'h0);
    check("t6_still_rq", 32'(bus_read_q), 32'h1);
    bus_read_dn = 1'b1;
    bus_rdata   = 32'hA5A55A5A;
    tick();
    bus_read_dn = 1'b0;
    req_read_q  = '0;
    check("t6_rdn", 32'(req_read_dn), 32'h1);
    check("t6_rdata", req_rdata, 32'hA5A55A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
